// File: rtl/s3_trit_packer.sv
// s3_trit_packer: packs mod-3 trits five per byte into little-endian 64-bit lanes for the hash unit.
// Optional macro TRIT_CHECK_EN adds a sticky trit_err output flagging accepted 2'b11 trits.
module s3_trit_packer #(
  parameter int N_TRITS    = 700,
  parameter int LANE_BYTES = 8
) (
  input  logic        ex_clk,
  input  logic        ovr_rst_n,
  input  logic        trit_valid,
  output logic        trit_ready,
  input  logic [1:0]  trit,
  input  logic        trit_last,
  output logic        lane_valid,
  input  logic        lane_ready,
  output logic [63:0] lane_data,
  output logic [3:0]  lane_bytes,
  output logic        lane_last,
  output logic [7:0]  byte_cnt,
  output logic        pack_done
`ifdef TRIT_CHECK_EN
  ,
  output logic        trit_err
`endif
);
  localparam int CW = $clog2(N_TRITS + 1);
  logic        en_q, en_d;
  logic [7:0]  acc_q, acc_d;
  logic [2:0]  w_q, w_d;
  logic [2:0]  s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] asm_q, asm_d;
  logic        asm_full_q, asm_full_d;
  logic [3:0]  asm_bytes_q, asm_bytes_d;
  logic        asm_last_q, asm_last_d;
  logic        lane_valid_q, lane_valid_d;
  logic [63:0] lane_data_q, lane_data_d;
  logic [3:0]  lane_bytes_q, lane_bytes_d;
  logic        lane_last_q, lane_last_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic        pack_done_q, pack_done_d;
  logic        acc, term, byte_done, lane_done, out_free, handshake, load;
  logic [1:0]  t;
  logic [7:0]  wt, byte_val;
  logic [63:0] merged;
`ifdef TRIT_CHECK_EN
  logic        trit_err_q, trit_err_d;
  assign trit_err = trit_err_q;
`endif
  assign trit_ready = en_q & ~asm_full_q;
  assign lane_valid = lane_valid_q;
  assign lane_data  = lane_data_q;
  assign lane_bytes = lane_bytes_q;
  assign lane_last  = lane_last_q;
  assign byte_cnt   = byte_cnt_q;
  assign pack_done  = pack_done_q;
  always_comb begin
    en_d = 1'b1;
    acc = trit_valid & trit_ready;
    t = (trit == 2'b11) ? 2'd0 : trit;
    wt = (w_q == 3'd0) ? 8'd1 : (w_q == 3'd1) ? 8'd3 : (w_q == 3'd2) ? 8'd9 : (w_q == 3'd3) ? 8'd27 : 8'd81;
    byte_val = acc_q + wt * {6'd0, t};
    term = acc & (trit_last | (cnt_q == CW'(N_TRITS - 1)));
    byte_done = acc & ((w_q == 3'd4) | term);
    lane_done = byte_done & ((s_q == 3'(LANE_BYTES - 1)) | term);
    merged = asm_q | ({56'd0, byte_val} << {s_q, 3'b000});
    out_free = ~lane_valid_q | lane_ready;
    handshake = lane_valid_q & lane_ready;
    // A finished lane goes straight to the output when it is free, else parks in assembly and stalls input
    load = (lane_done | asm_full_q) & out_free;
    acc_d = !acc ? acc_q : byte_done ? 8'd0 : byte_val;
    w_d = !acc ? w_q : byte_done ? 3'd0 : w_q + 3'd1;
    cnt_d = !acc ? cnt_q : term ? '0 : cnt_q + CW'(1);
    s_d = !byte_done ? s_q : lane_done ? 3'd0 : s_q + 3'd1;
    asm_d = load ? 64'd0 : byte_done ? merged : asm_q;
    asm_full_d = (lane_done | asm_full_q) & ~out_free;
    asm_bytes_d = lane_done ? {1'b0, s_q} + 4'd1 : asm_bytes_q;
    asm_last_d = lane_done ? term : asm_last_q;
    lane_valid_d = load | (lane_valid_q & ~lane_ready);
    lane_data_d = !load ? lane_data_q : asm_full_q ? asm_q : merged;
    lane_bytes_d = !load ? lane_bytes_q : asm_full_q ? asm_bytes_q : {1'b0, s_q} + 4'd1;
    lane_last_d = !load ? lane_last_q : asm_full_q ? asm_last_q : term;
    pack_done_d = handshake & lane_last_q;
    byte_cnt_d = pack_done_d ? {7'd0, byte_done} : byte_cnt_q + {7'd0, byte_done};
`ifdef TRIT_CHECK_EN
    trit_err_d = (trit_err_q & ~pack_done_q) | (acc & (trit == 2'b11));
`endif
  end
  always_ff @(posedge ex_clk or negedge ovr_rst_n) begin
    if (!ovr_rst_n) begin
      en_q <= 1'b0;
      acc_q <= '0;
      w_q <= '0;
      s_q <= '0;
      cnt_q <= '0;
      asm_q <= '0;
      asm_full_q <= 1'b0;
      asm_bytes_q <= '0;
      asm_last_q <= 1'b0;
      lane_valid_q <= 1'b0;
      lane_data_q <= '0;
      lane_bytes_q <= '0;
      lane_last_q <= 1'b0;
      byte_cnt_q <= '0;
      pack_done_q <= 1'b0;
`ifdef TRIT_CHECK_EN
      trit_err_q <= 1'b0;
`endif
    end else begin
      en_q <= en_d;
      acc_q <= acc_d;
      w_q <= w_d;
      s_q <= s_d;
      cnt_q <= cnt_d;
      asm_q <= asm_d;
      asm_full_q <= asm_full_d;
      asm_bytes_q <= asm_bytes_d;
      asm_last_q <= asm_last_d;
      lane_valid_q <= lane_valid_d;
      lane_data_q <= lane_data_d;
      lane_bytes_q <= lane_bytes_d;
      lane_last_q <= lane_last_d;
      byte_cnt_q <= byte_cnt_d;
      pack_done_q <= pack_done_d;
`ifdef TRIT_CHECK_EN
      trit_err_q <= trit_err_d;
`endif
    end
  end
endmodule

// File: tb/tb_s3_trit_packer.sv
// tb_s3_trit_packer: directed test of s3_trit_packer
module tb_s3_trit_packer;
  logic ex_clk = 1'b0;
  logic ovr_rst_n = 1'b0;
  logic trit_valid = 1'b0;
  logic trit_last = 1'b0;
  logic lane_ready = 1'b0;
  logic [1:0] trit = 2'd0;
  logic trit_ready, lane_valid, lane_last, pack_done;
  logic [63:0] lane_data;
  logic [3:0] lane_bytes;
  logic [7:0] byte_cnt;
`ifdef TRIT_CHECK_EN
  logic trit_err;
`endif
  int tests = 0;
  int fails = 0;
  int pd_cnt = 0;
  logic [63:0] qd[$];
  logic [3:0] qb[$];
  logic ql[$];
  always #5 ex_clk = ~ex_clk;
  s3_trit_packer dut (
    .ex_clk(ex_clk),
    .ovr_rst_n(ovr_rst_n),
    .trit_valid(trit_valid),
    .trit_ready(trit_ready),
    .trit(trit),
    .trit_last(trit_last),
    .lane_valid(lane_valid),
    .lane_ready(lane_ready),
    .lane_data(lane_data),
    .lane_bytes(lane_bytes),
    .lane_last(lane_last),
    .byte_cnt(byte_cnt),
    .pack_done(pack_done)
`ifdef TRIT_CHECK_EN
    ,
    .trit_err(trit_err)
`endif
  );
  always @(posedge ex_clk) begin
    if (lane_valid && lane_ready) begin
      qd.push_back(lane_data);
      qb.push_back(lane_bytes);
      ql.push_back(lane_last);
    end
    if (pack_done) pd_cnt++;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [1:0] t, input logic l);
    int n;
    n = 0;
    while (!trit_ready && n < 100) begin
      @(negedge ex_clk);
      n++;
    end
    if (n >= 100) chk("send_ready", {63'd0, trit_ready}, 64'd1);
    trit_valid = 1'b1;
    trit = t;
    trit_last = l;
    @(negedge ex_clk);
    trit_valid = 1'b0;
    trit_last = 1'b0;
  endtask
  task automatic clear_q();
    qd.delete();
    qb.delete();
    ql.delete();
  endtask
  task automatic wait_lanes(input int n);
    int k;
    k = 0;
    while (qd.size() < n && k < 50) begin
      @(negedge ex_clk);
      k++;
    end
    chk("lane_count", 64'(qd.size()), 64'(n));
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    #1;
    chk("rst_trit_ready", {63'd0, trit_ready}, 64'd0);
    chk("rst_lane_valid", {63'd0, lane_valid}, 64'd0);
    chk("rst_pack_done", {63'd0, pack_done}, 64'd0);
    chk("rst_byte_cnt", {56'd0, byte_cnt}, 64'd0);
    chk("rst_lane_data", lane_data, 64'd0);
    @(negedge ex_clk);
    @(negedge ex_clk);
    chk("rst_hold_ready", {63'd0, trit_ready}, 64'd0);
    ovr_rst_n = 1'b1;
    @(negedge ex_clk);
    chk("post_rst_ready", {63'd0, trit_ready}, 64'd1);
    lane_ready = 1'b1;
    // 1,0,0,0,0 | 0,1,0,0,0 | 2,2,2,2,2(last) -> bytes 01,03,F2
    send(2'd1, 1'b0);
    repeat (4) send(2'd0, 1'b0);
    send(2'd0, 1'b0);
    send(2'd1, 1'b0);
    repeat (3) send(2'd0, 1'b0);
    repeat (4) send(2'd2, 1'b0);
    send(2'd2, 1'b1);
    chk("t1_valid", {63'd0, lane_valid}, 64'd1);
    chk("t1_low24", {40'd0, lane_data[23:0]}, 64'hF20301);
    chk("t1_data", lane_data, 64'h0000_0000_00F2_0301);
    chk("t1_bytes", {60'd0, lane_bytes}, 64'd3);
    chk("t1_last", {63'd0, lane_last}, 64'd1);
    chk("t1_byte_cnt", {56'd0, byte_cnt}, 64'd3);
    @(negedge ex_clk);
    chk("t1_pack_done", {63'd0, pack_done}, 64'd1);
    chk("t1_cnt_clr", {56'd0, byte_cnt}, 64'd0);
    chk("t1_valid_drop", {63'd0, lane_valid}, 64'd0);
    @(negedge ex_clk);
    chk("t1_pd_pulse", {63'd0, pack_done}, 64'd0);
    // 1,1,1 with last -> 1+3+9 = 13
    send(2'd1, 1'b0);
    send(2'd1, 1'b0);
    send(2'd1, 1'b1);
    chk("t2_data", lane_data, 64'h0D);
    chk("t2_bytes", {60'd0, lane_bytes}, 64'd1);
    chk("t2_last", {63'd0, lane_last}, 64'd1);
    @(negedge ex_clk);
    chk("t2_pack_done", {63'd0, pack_done}, 64'd1);
    // 700 ones auto-terminate: 17 full lanes plus a 4-byte last lane of 0x79
    clear_q();
    repeat (700) send(2'd1, 1'b0);
    chk("t3_valid", {63'd0, lane_valid}, 64'd1);
    chk("t3_last", {63'd0, lane_last}, 64'd1);
    chk("t3_bytes", {60'd0, lane_bytes}, 64'd4);
    chk("t3_data", lane_data, 64'h0000_0000_7979_7979);
    chk("t3_byte_cnt", {56'd0, byte_cnt}, 64'd140);
    chk("t3_full_lanes", 64'(qd.size()), 64'd17);
    for (int i = 0; i < qd.size() && i < 17; i++) begin
      chk("t3_lane_data", qd[i], 64'h7979_7979_7979_7979);
      chk("t3_lane_bytes", {60'd0, qb[i]}, 64'd8);
      chk("t3_lane_last", {63'd0, ql[i]}, 64'd0);
    end
    @(negedge ex_clk);
    chk("t3_pack_done", {63'd0, pack_done}, 64'd1);
    chk("t3_cnt_clr", {56'd0, byte_cnt}, 64'd0);
    // Backpressure: lane of 2s held while a lane of 1s fills assembly
    lane_ready = 1'b0;
    clear_q();
    repeat (40) send(2'd2, 1'b0);
    chk("t4_latency", {63'd0, lane_valid}, 64'd1);
    chk("t4_first", lane_data, 64'hF2F2_F2F2_F2F2_F2F2);
    chk("t4_first_bytes", {60'd0, lane_bytes}, 64'd8);
    chk("t4_ready_mid", {63'd0, trit_ready}, 64'd1);
    repeat (40) send(2'd1, 1'b0);
    chk("t4_stall", {63'd0, trit_ready}, 64'd0);
    chk("t4_stable", lane_data, 64'hF2F2_F2F2_F2F2_F2F2);
    lane_ready = 1'b1;
    wait_lanes(2);
    if (qd.size() >= 2) begin
      chk("t4_drain0", qd[0], 64'hF2F2_F2F2_F2F2_F2F2);
      chk("t4_drain1", qd[1], 64'h7979_7979_7979_7979);
      chk("t4_drain1_last", {63'd0, ql[1]}, 64'd0);
    end
    send(2'd2, 1'b1);
    chk("t4_tail", lane_data, 64'h02);
    chk("t4_tail_last", {63'd0, lane_last}, 64'd1);
    chk("t4_byte_cnt", {56'd0, byte_cnt}, 64'd17);
    @(negedge ex_clk);
    chk("t4_pack_done", {63'd0, pack_done}, 64'd1);
    // Reset while a lane is pending and a partial byte is accumulating
    lane_ready = 1'b0;
    repeat (43) send(2'd1, 1'b0);
    chk("t5_pending", {63'd0, lane_valid}, 64'd1);
    pd_cnt = 0;
    #2;
    ovr_rst_n = 1'b0;
    #1;
    chk("t5_async_drop", {63'd0, lane_valid}, 64'd0);
    chk("t5_rst_ready", {63'd0, trit_ready}, 64'd0);
    @(negedge ex_clk);
    ovr_rst_n = 1'b1;
    @(negedge ex_clk);
    lane_ready = 1'b1;
    clear_q();
    repeat (4) send(2'd2, 1'b0);
    send(2'd2, 1'b1);
    chk("t5_data", lane_data, 64'hF2);
    chk("t5_bytes", {60'd0, lane_bytes}, 64'd1);
    chk("t5_no_pd", 64'(pd_cnt), 64'd0);
    @(negedge ex_clk);
    chk("t5_lanes", 64'(qd.size()), 64'd1);
    chk("t5_pack_done", {63'd0, pack_done}, 64'd1);
`ifdef TRIT_CHECK_EN
    send(2'd3, 1'b1);
    chk("t6_data", lane_data, 64'd0);
    chk("t6_bytes", {60'd0, lane_bytes}, 64'd1);
    chk("t6_err", {63'd0, trit_err}, 64'd1);
    @(negedge ex_clk);
    chk("t6_pd", {63'd0, pack_done}, 64'd1);
    chk("t6_err_pd", {63'd0, trit_err}, 64'd1);
    @(negedge ex_clk);
    chk("t6_err_clr", {63'd0, trit_err}, 64'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
